// File: rtl/auth_pkg.sv
// Shared state encoding and default parameters for the serial password gate.
package auth_pkg;
  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    NEWPW    = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  localparam logic [5:0] DEF_PW          = 6'b010011;
  localparam int         DEF_MAX_TRIES   = 3;
  localparam int         DEF_LOCK_CYCLES = 16;
endpackage

// File: rtl/auth_lock_timer.sv
// Loadable lockout down-counter; expire marks the edge on which the count leaves 1.
module auth_lock_timer #(
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rts,
  input  logic load,
  output logic expire
);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  logic [TW-1:0] cnt;

  always_ff @(negedge clk or negedge rts) begin
    if (!rts)            cnt <= '0;
    else if (load)       cnt <= TW'(LOCK_CYCLES);
    else if (cnt != '0)  cnt <= cnt - TW'(1);
  end

  // Seen by the FSM on the same edge that takes the count from 1 to 0.
  assign expire = (cnt == TW'(1));
endmodule

// File: rtl/auth_lockout.sv
// Serial password gate: bit collection, comparison, failure counting, lockout and reprogramming.
module auth_lockout
  import auth_pkg::*;
#(
  parameter int                PW_LEN      = 6,
  parameter logic [PW_LEN-1:0] PW_DEFAULT  = PW_LEN'(DEF_PW),
  parameter int                MAX_TRIES   = DEF_MAX_TRIES,
  parameter int                LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                             clk,
  input  logic                             rts,
  input  logic                             password,
  input  logic                             enter,
  input  logic                             logout,
  input  logic                             set_pw,
  output logic                             adderEnable,
  output logic                             adderDisable,
  output logic                             locked,
  output logic                             pw_fail,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);
  localparam int              IW   = $clog2(PW_LEN);
  localparam int              FW   = $clog2(MAX_TRIES + 1);
  localparam logic [IW-1:0]   LAST = IW'(PW_LEN - 1);

  state_t            state, nxt;
  logic [PW_LEN-1:0] stored_pw, sh, full;
  logic [IW-1:0]     bit_idx;
  logic              collect, fin, match, miss, to_lock, expire;

  auth_lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .clk    (clk),
    .rts    (rts),
    .load   (to_lock),
    .expire (expire)
  );

  always_comb begin
    full    = {password, sh[PW_LEN-2:0]};
    // logout beats a simultaneous final bit in NEWPW, so it also blocks collection.
    collect = enter && (state == ENTRY || (state == NEWPW && !logout));
    fin     = collect && (bit_idx == LAST);
    match   = (full == stored_pw);
    miss    = fin && (state == ENTRY) && !match;
    to_lock = miss && (fail_count + FW'(1) == FW'(MAX_TRIES));
    nxt     = state;
    unique case (state)
      ENTRY:    if (fin) nxt = match ? UNLOCKED : (to_lock ? LOCKED : ENTRY);
      UNLOCKED: if (logout) nxt = ENTRY; else if (set_pw) nxt = NEWPW;
      NEWPW:    if (logout) nxt = ENTRY; else if (fin) nxt = UNLOCKED;
      LOCKED:   if (expire) nxt = ENTRY;
      default:  nxt = ENTRY;
    endcase
  end

  always_ff @(negedge clk or negedge rts) begin
    if (!rts) begin
      state        <= ENTRY;
      stored_pw    <= PW_DEFAULT;
      sh           <= '0;
      bit_idx      <= '0;
      fail_count   <= '0;
      adderEnable  <= 1'b0;
      adderDisable <= 1'b1;
      locked       <= 1'b0;
      pw_fail      <= 1'b0;
    end else begin
      state        <= nxt;
      adderEnable  <= (nxt == UNLOCKED) || (nxt == NEWPW);
      adderDisable <= !((nxt == UNLOCKED) || (nxt == NEWPW));
      locked       <= (nxt == LOCKED);
      pw_fail      <= miss;

      if (collect) begin
        sh[bit_idx] <= password;
        bit_idx     <= fin ? '0 : bit_idx + IW'(1);
      end else if (nxt != state) begin
        bit_idx <= '0;
      end

      if ((state == ENTRY && fin && match) || (state == LOCKED && expire))
        fail_count <= '0;
      else if (miss)
        fail_count <= fail_count + FW'(1);

      if (state == NEWPW && fin)
        stored_pw <= full;
    end
  end
endmodule
